// File: rtl/pu_int_ctrl_pkg.sv
// Shared interrupt definitions for the PU interrupt controller: exception
// source bundles, the Int_ctrl_reg SPR layout, vector offsets and classes.
package pu_int_ctrl_pkg;

    localparam int GIN_W = 4;

    // Int_ctrl_reg SPR layout (bit 0 = gin_sense_level[0]).
    typedef struct packed {
        logic [18:0]      rsvd;
        logic             doorbell_en;
        logic [GIN_W-1:0] gin_mask;
        logic [GIN_W-1:0] gin_trigger;
        logic [GIN_W-1:0] gin_sense_level;
    } int_ctrl_reg_t;

    typedef logic except_mcheck_t;

    typedef struct packed {
        logic cinput;
        logic cdoorbell;
    } except_critical_t;

    typedef struct packed {
        logic ext_input;
        logic doorbell;
        logic alignment;
        logic illegal;
        logic unimplemented;
        logic trap;
    } except_base_t;

    typedef enum logic [1:0] {
        IC_BASE   = 2'd0,
        IC_CRIT   = 2'd1,
        IC_MCHECK = 2'd2
    } int_class_t;

    // Interrupt vector offsets (word addresses).
    localparam logic [11:0] IVO_MCHECK    = 12'h001;
    localparam logic [11:0] IVO_CINPUT    = 12'h002;
    localparam logic [11:0] IVO_EXT_INPUT = 12'h005;
    localparam logic [11:0] IVO_ALIGNMENT = 12'h006;
    localparam logic [11:0] IVO_PROGRAM   = 12'h007;
    localparam logic [11:0] IVO_DOORBELL  = 12'h009;
    localparam logic [11:0] IVO_CDOORBELL = 12'h00a;

    // Grantable sources; values 0..7 double as sticky pending bit indices.
    typedef enum logic [3:0] {
        SRC_MCHECK    = 4'd0,
        SRC_CINPUT    = 4'd1,
        SRC_CDOORBELL = 4'd2,
        SRC_ILLEGAL   = 4'd3,
        SRC_UNIMPL    = 4'd4,
        SRC_TRAP      = 4'd5,
        SRC_ALIGN     = 4'd6,
        SRC_DOORBELL  = 4'd7,
        SRC_EXT       = 4'd8
    } int_src_t;

    localparam int NUM_STICKY = 8;

    function automatic logic [11:0] src_vector(input int_src_t src);
        case (src)
            SRC_MCHECK:    return IVO_MCHECK;
            SRC_CINPUT:    return IVO_CINPUT;
            SRC_CDOORBELL: return IVO_CDOORBELL;
            SRC_ILLEGAL,
            SRC_UNIMPL,
            SRC_TRAP:      return IVO_PROGRAM;
            SRC_ALIGN:     return IVO_ALIGNMENT;
            SRC_EXT:       return IVO_EXT_INPUT;
            SRC_DOORBELL:  return IVO_DOORBELL;
            default:       return 12'h000;
        endcase
    endfunction

    function automatic int_class_t src_class(input int_src_t src);
        case (src)
            SRC_MCHECK:               return IC_MCHECK;
            SRC_CINPUT, SRC_CDOORBELL: return IC_CRIT;
            default:                  return IC_BASE;
        endcase
    endfunction

endpackage

// File: rtl/pu_int_ctrl_gin.sv
// External gin pins: synchroniser, polarity, edge/level sense and the
// per-pin pending bit, replicated across all pins.
module pu_int_ctrl_gin
    import pu_int_ctrl_pkg::*;
#(
    parameter int NUM_GIN     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_GIN-1:0] gin,
    input  logic [NUM_GIN-1:0] sense_level,
    input  logic [NUM_GIN-1:0] trigger,
    input  logic [NUM_GIN-1:0] clear,
    output logic [NUM_GIN-1:0] pending
);

    for (genvar gi = 0; gi < NUM_GIN; gi++) begin : g_pin
        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   hist_reg;
        logic                   rise_reg;
        logic                   edge_pend_reg;
        logic                   pol;

        // trigger=0 means active-high / rising edge
        assign pol = sync_reg[SYNC_STAGES-1] ^ trigger[gi];

        // Synchronise, remember last polarity, register the rise, hold edge pending (set wins over clear)
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_reg      <= '0;
                hist_reg      <= 1'b0;
                rise_reg      <= 1'b0;
                edge_pend_reg <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], gin[gi]};
                hist_reg <= pol;
                rise_reg <= pol & ~hist_reg;
                if (sense_level[gi]) begin
                    edge_pend_reg <= 1'b0;
                end else begin
                    edge_pend_reg <= rise_reg | (edge_pend_reg & ~clear[gi]);
                end
            end
        end

        // Level pins follow the synchronised input directly
        assign pending[gi] = sense_level[gi] ? pol : edge_pend_reg;
    end

endmodule

// File: rtl/pu_int_ctrl.sv
// PU interrupt controller: latches exception sources, prioritises them
// against the MSR enables and hands one vector to fetch over req/ack.
module pu_int_ctrl
    import pu_int_ctrl_pkg::*;
#(
    parameter int NUM_GIN     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ctrl,
    input  logic [NUM_GIN-1:0] gin,
    input  logic [NUM_GIN-1:0] gin_clear,
    output logic [NUM_GIN-1:0] gin_pending,
    input  logic               except_mcheck,
    input  logic [1:0]         except_crit,
    input  logic [5:0]         except_base,
    input  logic               msr_me,
    input  logic               msr_ce,
    input  logic               msr_ee,
    output logic               int_req,
    output logic [11:0]        int_vector,
    output logic [1:0]         int_class,
    input  logic               int_ack
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    int_ctrl_reg_t          ctrl_reg;
    except_critical_t       crit;
    except_base_t           base;
    logic                   ctrl_unused;

    logic [0:0]             state_reg;
    int_src_t               grant_src_reg;
    logic [11:0]            vector_reg;
    int_class_t             class_reg;
    logic [NUM_STICKY-1:0]  sticky_reg;
    logic [NUM_STICKY-1:0]  sticky_set;
    logic [NUM_STICKY-1:0]  sticky_clr;
    logic                   ext_input;
    logic                   ack_fire;
    logic                   sel_valid;
    int_src_t               sel_src;

    assign ctrl_reg    = ctrl;
    assign crit        = except_crit;
    assign base        = except_base;
    assign ctrl_unused = ^ctrl_reg.rsvd;

    pu_int_ctrl_gin #(
        .NUM_GIN     (NUM_GIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gin (
        .clk         (clk),
        .reset       (reset),
        .gin         (gin),
        .sense_level (ctrl_reg.gin_sense_level[NUM_GIN-1:0]),
        .trigger     (ctrl_reg.gin_trigger[NUM_GIN-1:0]),
        .clear       (gin_clear),
        .pending     (gin_pending)
    );

    // External input is not sticky: it follows the gin pending bits and the pipeline line
    assign ext_input = (|(gin_pending & ctrl_reg.gin_mask[NUM_GIN-1:0])) | base.ext_input;

    assign sticky_set[SRC_MCHECK]    = except_mcheck;
    assign sticky_set[SRC_CINPUT]    = crit.cinput;
    assign sticky_set[SRC_CDOORBELL] = crit.cdoorbell;
    assign sticky_set[SRC_ILLEGAL]   = base.illegal;
    assign sticky_set[SRC_UNIMPL]    = base.unimplemented;
    assign sticky_set[SRC_TRAP]      = base.trap;
    assign sticky_set[SRC_ALIGN]     = base.alignment;
    assign sticky_set[SRC_DOORBELL]  = base.doorbell & ctrl_reg.doorbell_en;

    assign ack_fire   = (state_reg == ST_REQ) && int_ack;
    // Only the granted sticky source is cleared; ext_input has no sticky bit
    assign sticky_clr = (ack_fire && grant_src_reg != SRC_EXT)
                        ? (NUM_STICKY'(1) << grant_src_reg) : '0;

    // Sticky pending bits; a new event in the ack cycle keeps the source pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= sticky_set | (sticky_reg & ~sticky_clr);
        end
    end

    // Fixed-priority pick among enabled pending sources; sync exceptions ignore msr_ee
    always_comb begin
        sel_valid = 1'b1;
        sel_src   = SRC_MCHECK;
        if (sticky_reg[SRC_MCHECK] && msr_me)          sel_src = SRC_MCHECK;
        else if (sticky_reg[SRC_CINPUT] && msr_ce)     sel_src = SRC_CINPUT;
        else if (sticky_reg[SRC_CDOORBELL] && msr_ce)  sel_src = SRC_CDOORBELL;
        else if (sticky_reg[SRC_ILLEGAL])              sel_src = SRC_ILLEGAL;
        else if (sticky_reg[SRC_UNIMPL])               sel_src = SRC_UNIMPL;
        else if (sticky_reg[SRC_TRAP])                 sel_src = SRC_TRAP;
        else if (sticky_reg[SRC_ALIGN])                sel_src = SRC_ALIGN;
        else if (ext_input && msr_ee)                  sel_src = SRC_EXT;
        else if (sticky_reg[SRC_DOORBELL] && msr_ee)   sel_src = SRC_DOORBELL;
        else                                           sel_valid = 1'b0;
    end

    // Request FSM: capture the winner on IDLE->REQ and hold it untouched until ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            grant_src_reg <= SRC_MCHECK;
            vector_reg    <= '0;
            class_reg     <= IC_BASE;
        end else if (state_reg == ST_IDLE) begin
            if (sel_valid) begin
                state_reg     <= ST_REQ;
                grant_src_reg <= sel_src;
                vector_reg    <= src_vector(sel_src);
                class_reg     <= src_class(sel_src);
            end
        end else if (int_ack) begin
            state_reg <= ST_IDLE;
        end
    end

    assign int_req    = (state_reg == ST_REQ);
    assign int_vector = vector_reg;
    assign int_class  = class_reg;

endmodule
